// File: rtl/round_trace_pkg.sv
// Shared types for the round trace buffer: capture FSM states and the FIFO entry layout.
// Optional dedup of repeated network states is enabled with ROUND_TRACE_DEDUP_EN.
package round_trace_pkg;

  localparam int TRACE_ROUND_W = 10;
  localparam int TRACE_WIDTH   = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } trace_state_e;

  // Reference layout at default widths; the top re-declares it at its own parameter widths.
  typedef struct packed {
    logic                     last;
    logic [TRACE_ROUND_W-1:0] round;
    logic [TRACE_WIDTH-1:0]   state;
  } trace_entry_t;

  function automatic int entry_bits(input int round_w, input int width);
    return 1 + round_w + width;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO with flush; head data reads as zero while empty.
// Push is accepted when not full or when a pop happens in the same cycle.
module trace_fifo #(
  parameter int ENTRY_W   = 75,
  parameter int DEPTH     = 16,
  parameter int LOG_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push,
  input  logic [ENTRY_W-1:0]   push_data,
  input  logic                 pop,
  output logic [ENTRY_W-1:0]   rd_data,
  output logic                 push_ok,
  output logic                 full,
  output logic                 empty,
  output logic [LOG_DEPTH:0]   count
);

  localparam logic [LOG_DEPTH:0] FULL_CNT = (LOG_DEPTH+1)'(DEPTH);

  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic                 pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Flush beats both push and pop in the same cycle.
  always_comb begin
    push_ok  = push && !flush && (!full || pop);
    pop_ok   = pop && !flush && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + LOG_DEPTH'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + LOG_DEPTH'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (LOG_DEPTH+1)'(1);
        2'b01:   count_d = count_q - (LOG_DEPTH+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/round_trace_buffer.sv
// Records one snapshot per completed datapath round into a FIFO and streams them to the host.
// Define ROUND_TRACE_DEDUP_EN to skip round captures whose state repeats the last stored one.
module round_trace_buffer
  import round_trace_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int ROUND_W   = TRACE_ROUND_W,
  parameter int DEPTH     = 16,
  parameter int LOG_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic [WIDTH-1:0]     network_state,
  input  logic [ROUND_W-1:0]   round_number,
  input  logic                 steady_state,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_state,
  output logic [ROUND_W-1:0]   out_round,
  output logic                 out_last,
  output logic [LOG_DEPTH:0]   count,
  output logic                 overflow,
  output logic                 done
);

  localparam int ENTRY_W = entry_bits(ROUND_W, WIDTH);

  typedef struct packed {
    logic               last;
    logic [ROUND_W-1:0] round;
    logic [WIDTH-1:0]   state;
  } entry_t;

  // Handshake: the head entry transfers on a rising clk edge where out_valid && out_ready;
  // out_valid never depends on out_ready, and the head is held stable until it transfers.

  trace_state_e       state_q, state_d;
  logic [ROUND_W-1:0] prev_round_q, prev_round_d;
  logic               init_q, init_d;
  logic               overflow_q, overflow_d;
  logic               capturing;
  logic               push_req;
  logic               push_ok;
  logic               fifo_full;
  logic               fifo_empty;
  entry_t             push_entry;
  entry_t             head_entry;
  logic [ENTRY_W-1:0] head_bits;

`ifdef ROUND_TRACE_DEDUP_EN
  logic [WIDTH-1:0]   last_pushed_q, last_pushed_d;
`endif

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm) state_d = CAPTURE;
      CAPTURE: begin
        if (arm)               state_d = CAPTURE;
        else if (steady_state) state_d = DONE;
      end
      DONE:    if (arm) state_d = CAPTURE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    capturing = (state_q == CAPTURE);
    done      = (state_q == DONE);
  end

  // Capture trigger: the post-arm initial entry, any round change (wrap included) or steady state.
  // A steady-state cycle yields exactly one entry even if the round also changed.
  always_comb begin
    push_req     = 1'b0;
    prev_round_d = prev_round_q;
    init_d       = 1'b0;
    overflow_d   = overflow_q;
    push_entry   = '{last: steady_state, round: round_number, state: network_state};
    if (arm) begin
      prev_round_d = round_number;
      init_d       = 1'b1;
      overflow_d   = 1'b0;
    end else if (capturing) begin
      if (init_q || (round_number != prev_round_q) || steady_state) begin
        push_req     = 1'b1;
        prev_round_d = round_number;
`ifdef ROUND_TRACE_DEDUP_EN
        if (!steady_state && !init_q && (network_state == last_pushed_q)) push_req = 1'b0;
`endif
      end
      if (push_req && !push_ok) overflow_d = 1'b1;
    end
  end

`ifdef ROUND_TRACE_DEDUP_EN
  always_comb begin
    last_pushed_d = last_pushed_q;
    if (arm)          last_pushed_d = '0;
    else if (push_ok) last_pushed_d = network_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_pushed_q <= '0;
    else     last_pushed_q <= last_pushed_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_round_q <= '0;
      init_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      prev_round_q <= prev_round_d;
      init_q       <= init_d;
      overflow_q   <= overflow_d;
    end
  end

  trace_fifo #(
    .ENTRY_W   (ENTRY_W),
    .DEPTH     (DEPTH),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (arm),
    .push      (push_req),
    .push_data (push_entry),
    .pop       (out_ready),
    .rd_data   (head_bits),
    .push_ok   (push_ok),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign head_entry = entry_t'(head_bits);
  assign out_valid  = !fifo_empty;
  assign out_state  = head_entry.state;
  assign out_round  = head_entry.round;
  assign out_last   = head_entry.last;
  assign overflow   = overflow_q;

  // Full status is implied by push_ok; kept visible for debug probing.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_round_trace_buffer.sv
// Scoreboard bench for round_trace_buffer: directed test-plan runs plus randomized traffic
// against a queue-based reference model.
module tb_round_trace_buffer;

  localparam int WIDTH     = 64;
  localparam int ROUND_W   = 10;
  localparam int DEPTH     = 16;
  localparam int LOG_DEPTH = 4;
  localparam int W         = 1 + ROUND_W + WIDTH;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 arm;
  logic [WIDTH-1:0]     network_state;
  logic [ROUND_W-1:0]   round_number;
  logic                 steady_state;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_state;
  logic [ROUND_W-1:0]   out_round;
  logic                 out_last;
  logic [LOG_DEPTH:0]   count;
  logic                 overflow;
  logic                 done;

  round_trace_buffer #(
    .WIDTH(WIDTH), .ROUND_W(ROUND_W), .DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .network_state(network_state),
    .round_number(round_number), .steady_state(steady_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .out_round(out_round), .out_last(out_last), .count(count),
    .overflow(overflow), .done(done)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0]       exp_q[$];
  bit                 m_cap, m_done, m_ovf, m_init;
  logic [ROUND_W-1:0] m_prev;
  logic [WIDTH-1:0]   m_last_pushed;

  int vectors    = 0;
  int miscompares = 0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_cap = 0; m_done = 0; m_ovf = 0; m_init = 0; m_prev = '0; m_last_pushed = '0;
  endtask

  // Applied after the monitor has popped for this cycle, so size() < DEPTH covers pop-and-push.
  task automatic model_step(input bit a, input logic [ROUND_W-1:0] r,
                            input logic [WIDTH-1:0] s, input bit st);
    bit store;
    if (a) begin
      exp_q.delete();
      m_ovf = 0; m_done = 0; m_cap = 1; m_init = 1; m_prev = r; m_last_pushed = '0;
    end else if (m_cap) begin
      if (m_init || r != m_prev || st) begin
        store = 1;
`ifdef ROUND_TRACE_DEDUP_EN
        if (!st && !m_init && s == m_last_pushed) store = 0;
`endif
        if (store) begin
          if (exp_q.size() < DEPTH) begin
            exp_q.push_back({st, r, s});
            m_last_pushed = s;
          end else begin
            m_ovf = 1;
          end
        end
        m_prev = r;
        if (st) begin
          m_cap = 0;
          m_done = 1;
        end
      end
      m_init = 0;
    end
  endtask

  // Driver: inputs change just after the rising edge; model advances after the monitor sample.
  task automatic drive(input bit a, input logic [ROUND_W-1:0] r, input logic [WIDTH-1:0] s,
                       input bit st, input bit rdy);
    arm = a; round_number = r; network_state = s; steady_state = st; out_ready = rdy;
    @(negedge clk);
    #1;
    model_step(a, r, s, st);
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst) begin
      check("count", count, exp_q.size());
      check("out_valid", out_valid, exp_q.size() != 0);
      check("overflow", overflow, m_ovf);
      check("done", done, m_done);
      if (out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("head_entry", {out_last, out_round, out_state}, e);
      end
    end
  end

  logic [ROUND_W-1:0] r_cur;

  initial begin
    rst = 1'b1; arm = 0; network_state = '0; round_number = '0; steady_state = 0; out_ready = 0;
    model_reset();
    #3;
    check("reset_out_valid", out_valid, 0);
    check("reset_count", count, 0);
    check("reset_overflow", overflow, 0);
    check("reset_done", done, 0);
    check("reset_out_state", {out_last, out_round, out_state}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic stream of three rounds
    drive(1, 10'd0, 64'h5, 0, 1);
    drive(0, 10'd0, 64'h5, 0, 1);
    drive(0, 10'd1, 64'hA, 0, 1);
    drive(0, 10'd2, 64'hF, 0, 1);
    drive(0, 10'd2, 64'hF, 0, 1);
    drive(0, 10'd2, 64'hF, 0, 1);
    check("stream_drained", count, 0);

    // Steady state together with a round change: single last entry, then nothing more
    drive(0, 10'd3, 64'h3C, 1, 0);
    check("steady_done", done, 1);
    check("steady_count", count, 1);
    check("steady_last", {out_last, out_round, out_state}, {1'b1, 10'd3, 64'h3C});
    drive(0, 10'd4, 64'h44, 0, 1);
    drive(0, 10'd5, 64'h55, 0, 1);
    drive(0, 10'd6, 64'h66, 0, 1);
    check("done_no_push", count, 0);

    // Overflow: 20 round changes into a 16-entry FIFO, then drain
    drive(1, 10'd0, 64'h100, 0, 0);
    drive(0, 10'd0, 64'h100, 0, 0);
    for (int i = 1; i < 20; i++) drive(0, 10'(i), 64'(i * 3), 0, 0);
    check("full_count", count, DEPTH);
    check("full_overflow", overflow, 1);
    for (int i = 0; i < 18; i++) drive(0, 10'd19, 64'h39, 0, 1);
    check("drain_count", count, 0);
    check("drain_overflow_sticky", overflow, 1);

    // Round counter wrap
    drive(1, 10'd1022, 64'h1, 0, 1);
    check("arm_clears_overflow", overflow, 0);
    drive(0, 10'd1022, 64'h1, 0, 1);
    drive(0, 10'd1023, 64'h2, 0, 1);
    drive(0, 10'd0, 64'h3, 0, 1);
    repeat (3) drive(0, 10'd0, 64'h3, 0, 1);

    // Repeated state across rounds (stored or skipped depending on build)
    drive(1, 10'd0, 64'h0, 0, 1);
    drive(0, 10'd0, 64'h0, 0, 1);
    drive(0, 10'd1, 64'h7, 0, 1);
    drive(0, 10'd2, 64'h7, 0, 1);
    drive(0, 10'd3, 64'h9, 0, 1);
    repeat (3) drive(0, 10'd3, 64'h9, 0, 1);

    // Randomized traffic
    r_cur = 10'($urandom_range(0, 1023));
    for (int i = 0; i < 800; i++) begin
      bit a, st, rdy;
      a = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 29) == 0);
      rdy = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) r_cur = r_cur + 10'($urandom_range(1, 3));
      drive(a, r_cur, 64'($urandom_range(0, 3)), st, rdy);
    end

    // Asynchronous reset mid-capture with five entries held
    drive(1, 10'd40, 64'hAA, 0, 0);
    drive(0, 10'd40, 64'hAA, 0, 0);
    for (int i = 41; i < 45; i++) drive(0, 10'(i), 64'(i), 0, 0);
    check("pre_reset_count", count, 5);
    rst = 1'b1;
    #2;
    check("async_out_valid", out_valid, 0);
    check("async_count", count, 0);
    check("async_overflow", overflow, 0);
    check("async_done", done, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 10'd50, 64'h50, 0, 1);
    drive(0, 10'd51, 64'h51, 0, 1);
    check("idle_after_reset", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/round_trace_buffer.md
Name: round_trace_buffer

Overview:
- Downstream consumer of the random-order asynchronous simulation datapath.
- Watches network_state, round_number and steady_state, and records one snapshot per completed round into an on-chip FIFO.
- Streams snapshots to the host interface over a valid/ready handshake; flags the final (steady-state) entry.
- Lets software reconstruct the full trajectory of one simulation run without polling.

Parameters:
- WIDTH, 64, network state width (set to `RULES at instantiation)
- ROUND_W, 10, round counter width (matches datapath round_number)
- DEPTH, 16, FIFO entries (power of 2)
- LOG_DEPTH, 4, log2(DEPTH)

Ports:
- clk  in  1  system clock, all state rising-edge
- rst  in  1  asynchronous, active-high reset
- arm  in  1  one-cycle pulse; clears buffer and begins a capture run (tie to datapath start)
- network_state  in  WIDTH  masked network state from datapath
- round_number  in  ROUND_W  datapath round counter
- steady_state  in  1  datapath steady-state flag
- out_valid  out  1  head entry available
- out_ready  in  1  host accepts head entry
- out_state  out  WIDTH  head entry network state
- out_round  out  ROUND_W  head entry round tag
- out_last  out  1  head entry is the steady-state entry
- count  out  LOG_DEPTH+1  current occupancy
- overflow  out  1  sticky: at least one capture dropped this run
- done  out  1  run finished (steady state seen)

Behaviour:
- Reset (async, any time, including mid-run):
  - FSM=IDLE; FIFO empty; rd/wr pointers=0; count=0.
  - out_valid=0, out_last=0, overflow=0, done=0.
  - prev_round=0; out_state/out_round=0.
- FSM states IDLE, CAPTURE, DONE:
  - IDLE: ignores inputs; arm -> CAPTURE.
  - CAPTURE: arm -> restart (see below); steady_state=1 -> DONE after final capture.
  - DONE: holds done=1; FIFO keeps draining; arm -> CAPTURE.
- Arm (from any state, including CAPTURE/DONE):
  - Same cycle: FIFO flushed (pointers/count=0), overflow=0, done=0.
  - Same cycle: prev_round<=round_number.
  - Cycle after arm: pushes initial entry {last=0, round=round_number, state=network_state}.
- Capture trigger in CAPTURE, evaluated each cycle:
  - round_number != prev_round -> push {state=network_state, round=round_number}; prev_round<=round_number.
  - Inequality compare, so the ROUND_W wrap 1023->0 is a valid change.
- steady_state=1 in CAPTURE -> push one entry with last=1 (round=round_number), then go to DONE.
  - If a round change occurs the same cycle, exactly one entry is pushed (last=1), not two.
- Push acceptance: accepted if count<DEPTH, or a pop occurs the same cycle (pop-and-push when full is legal; count unchanged).
- Full drop:
  - Push while full with no pop: entry dropped; overflow<=1 (sticky until arm/rst); FIFO contents unchanged.
  - A dropped last entry still moves FSM to DONE; out_last is then never presented.
- FIFO output is first-word-fall-through:
  - out_valid=(count!=0); out_state/out_round/out_last reflect head entry combinationally from storage.
  - Pop when out_valid&&out_ready.
  - out_ready with out_valid=0 has no effect.
  - Outputs held stable while out_valid&&!out_ready.
- Latency: entry pushed at clock edge t is visible on out_* with out_valid=1 after edge t (one cycle from trigger).
- Pointers wrap modulo DEPTH; count is LOG_DEPTH+1 bits so full (count==DEPTH) is distinguishable from empty.
- Arm same cycle as pop: flush wins, pop ignored.

Optional Feature:
- Macro: ROUND_TRACE_DEDUP_EN.
- Defined:
  - Non-last round-change captures whose network_state equals the last pushed state are not stored; they do not set overflow.
  - The last=1 entry is always stored.
  - Adds a WIDTH-bit last_pushed register, cleared on arm/rst.
- Undefined: every round change is stored; no extra register.

Decomposition:
- Package round_trace_pkg:
  - trace_state_e enum {IDLE, CAPTURE, DONE}.
  - Packed struct trace_entry_t {last, round[ROUND_W], state[WIDTH]}.
  - Localparam TRACE_ROUND_W=10.
- Sub-module trace_fifo:
  - Synchronous FWFT FIFO, parameterised by entry width/DEPTH.
  - Async-reset pointers/count; flush input; push/pop; full/empty/count.
- Top block holds FSM, prev_round, trigger, overflow and done logic.

Test Plan:
- Arm with round_number=0, state=0x5; round steps 0->1->2 with states 0xA, 0xF; out_ready=1 -> stream (0,0x5),(1,0xA),(2,0xF), count returns to 0.
- round_number=3 and steady_state rise on same cycle, state=0x3C -> single entry {round=3, state=0x3C, last=1}; done=1 next cycle; no further pushes on later round changes.
- out_ready=0, DEPTH=16, 20 round changes -> count=16, overflow=1; then drain -> entries rounds 0..15 in order, overflow stays 1 until next arm.
- round_number 1022->1023->0 -> three entries, out_round 1022, 1023, 0.
- rst asserted asynchronously mid-CAPTURE with count=5 -> out_valid, count, overflow, done all 0 before next clk edge.
- ROUND_TRACE_DEDUP_EN defined, states 0x7,0x7,0x9 on rounds 1,2,3 -> entries rounds 1 and 3 only; undefined -> all three.
